// File: rtl/rotozoom_scheduler.sv
// rotozoom_scheduler: per-frame angle/zoom setup and per-pixel texture coordinate walker
// Ports:
//   clk, reset              pixel clock, asynchronous active-high reset
//   frame_start             restarts setup (SIN -> COS -> MUL -> RUN)
//   line_start, pixel_en    row load / pixel step while in RUN
//   speed, pause            angle increment per frame, freeze of angle and frame counter
//   u, v                    texture coordinates, unsigned (COORD_W-8).8
//   angle                   current angle, 64 steps per turn
//   ready                   high while in RUN
module rotozoom_scheduler #(
    parameter int COORD_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               line_start,
    input  logic               pixel_en,
    input  logic [1:0]         speed,
    input  logic               pause,
    output logic [COORD_W-1:0] u,
    output logic [COORD_W-1:0] v,
    output logic [5:0]         angle,
    output logic               ready
);
    typedef enum logic [2:0] {IDLE, SIN, COS, MUL, RUN} state_t;

    state_t              state_q, state_d;
    logic [COORD_W-1:0]  u_q, u_d, v_q, v_d;
    logic [COORD_W-1:0]  row_u_q, row_u_d, row_v_q, row_v_d;
    logic [COORD_W-1:0]  du_q, du_d, dv_q, dv_d;
    logic signed [7:0]   sin_r_q, sin_r_d, cos_r_q, cos_r_d;
    logic [5:0]          angle_q, angle_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;

    logic [5:0]          tbl_a;
    logic [4:0]          tbl_idx;
    logic [6:0]          tbl_mag;
    logic signed [7:0]   sin_val;
    logic [3:0]          zoom_t;
    logic [4:0]          zoom;
    logic signed [12:0]  prod_c, prod_s;

    function automatic logic [6:0] lut(input logic [4:0] idx);
        case (idx)
            5'd0:    lut = 7'd0;
            5'd1:    lut = 7'd12;
            5'd2:    lut = 7'd25;
            5'd3:    lut = 7'd37;
            5'd4:    lut = 7'd49;
            5'd5:    lut = 7'd60;
            5'd6:    lut = 7'd71;
            5'd7:    lut = 7'd81;
            5'd8:    lut = 7'd90;
            5'd9:    lut = 7'd98;
            5'd10:   lut = 7'd106;
            5'd11:   lut = 7'd112;
            5'd12:   lut = 7'd117;
            5'd13:   lut = 7'd122;
            5'd14:   lut = 7'd125;
            5'd15:   lut = 7'd126;
            5'd16:   lut = 7'd127;
            default: lut = 7'd0;
        endcase
    endfunction

    // One shared quarter-wave table: COS reads it at angle+16, every other state at angle.
    always_comb begin
        tbl_a   = angle_q + ((state_q == COS) ? 6'd16 : 6'd0);
        tbl_idx = tbl_a[4] ? 5'd16 - {1'b0, tbl_a[3:0]} : {1'b0, tbl_a[3:0]};
        tbl_mag = lut(tbl_idx);
        sin_val = tbl_a[5] ? -$signed({1'b0, tbl_mag}) : $signed({1'b0, tbl_mag});
    end

    // Zoom is a triangle wave over frame_cnt[6:2], 4..19.
    always_comb begin
        zoom_t = frame_cnt_q[6] ? ~frame_cnt_q[5:2] : frame_cnt_q[5:2];
        zoom   = 5'd4 + {1'b0, zoom_t};
        prod_c = cos_r_q * $signed({1'b0, zoom});
        prod_s = sin_r_q * $signed({1'b0, zoom});
    end

    always_comb begin
        state_d     = state_q;
        u_d         = u_q;
        v_d         = v_q;
        row_u_d     = row_u_q;
        row_v_d     = row_v_q;
        du_d        = du_q;
        dv_d        = dv_q;
        sin_r_d     = sin_r_q;
        cos_r_d     = cos_r_q;
        angle_d     = angle_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            state_d = SIN;
            if (!pause) begin
                angle_d     = angle_q + {4'd0, speed};
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                SIN: begin
                    sin_r_d = sin_val;
                    state_d = COS;
                end
                COS: begin
                    cos_r_d = sin_val;
                    state_d = MUL;
                end
                MUL: begin
                    du_d    = {{(COORD_W-13){prod_c[12]}}, prod_c};
                    dv_d    = {{(COORD_W-13){prod_s[12]}}, prod_s};
                    row_u_d = '0;
                    row_v_d = '0;
                    state_d = RUN;
                end
                RUN: begin
                    // A row load takes priority and swallows a coincident pixel step.
                    if (line_start) begin
                        u_d     = row_u_q;
                        v_d     = row_v_q;
                        row_u_d = row_u_q - dv_q;
                        row_v_d = row_v_q + du_q;
                    end else if (pixel_en) begin
                        u_d = u_q + du_q;
                        v_d = v_q + dv_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            u_q         <= '0;
            v_q         <= '0;
            row_u_q     <= '0;
            row_v_q     <= '0;
            du_q        <= '0;
            dv_q        <= '0;
            sin_r_q     <= '0;
            cos_r_q     <= '0;
            angle_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            u_q         <= u_d;
            v_q         <= v_d;
            row_u_q     <= row_u_d;
            row_v_q     <= row_v_d;
            du_q        <= du_d;
            dv_q        <= dv_d;
            sin_r_q     <= sin_r_d;
            cos_r_q     <= cos_r_d;
            angle_q     <= angle_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign u     = u_q;
    assign v     = v_q;
    assign angle = angle_q;
    assign ready = (state_q == RUN);
endmodule

// File: tb/tb_rotozoom_scheduler.sv
// tb_rotozoom_scheduler: checks rotozoom_scheduler against a behavioural frame/line/pixel model
module tb_rotozoom_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        pixel_en = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        pause = 1'b0;
    logic [15:0] u, v;
    logic [5:0]  angle;
    logic        ready;

    int checks = 0;
    int failures = 0;

    rotozoom_scheduler #(.COORD_W(16)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .pixel_en(pixel_en), .speed(speed), .pause(pause),
        .u(u), .v(v), .angle(angle), .ready(ready)
    );

    always #5 clk = ~clk;

    // Behavioural model: values are derived with plain integer arithmetic.
    int          lt[17] = '{0,12,25,37,49,60,71,81,90,98,106,112,117,122,125,126,127};
    int          m_angle, m_fc, m_since;
    logic [15:0] m_u, m_v, m_row_u, m_row_v, m_du, m_dv;

    function automatic int sine(input int a);
        int q, i;
        q = (a % 64) / 16;
        i = a % 16;
        return (q == 0) ? lt[i] : (q == 1) ? lt[16-i] : (q == 2) ? -lt[i] : -lt[16-i];
    endfunction

    function automatic int zoom_of(input int fc);
        int t;
        t = (fc / 4) % 16;
        return 4 + (((fc / 64) % 2 == 1) ? 15 - t : t);
    endfunction

    // m_since counts edges since the accepted frame_start (-1 = never started); 3 means running.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_angle = 0; m_fc = 0; m_since = -1;
            m_u = 0; m_v = 0; m_row_u = 0; m_row_v = 0; m_du = 0; m_dv = 0;
        end else if (frame_start) begin
            if (!pause) begin
                m_angle = (m_angle + int'(speed)) % 64;
                m_fc = (m_fc + 1) % 256;
            end
            m_since = 0;
        end else if (m_since >= 0 && m_since < 3) begin
            m_since++;
            if (m_since == 3) begin
                m_du = 16'(sine(m_angle + 16) * zoom_of(m_fc));
                m_dv = 16'(sine(m_angle) * zoom_of(m_fc));
                m_row_u = 0; m_row_v = 0;
            end
        end else if (m_since == 3) begin
            if (line_start) begin
                m_u = m_row_u; m_v = m_row_v;
                m_row_u = m_row_u - m_dv; m_row_v = m_row_v + m_du;
            end else if (pixel_en) begin
                m_u = m_u + m_du; m_v = m_v + m_dv;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_u", int'(u), int'(m_u));
        check("model_v", int'(v), int'(m_v));
        check("model_angle", int'(angle), m_angle);
        check("model_ready", int'(ready), int'(m_since == 3));
    end

    task automatic cyc(input logic fs, input logic ls, input logic pe);
        frame_start = fs; line_start = ls; pixel_en = pe;
        @(negedge clk);
        frame_start = 1'b0; line_start = 1'b0; pixel_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_u", int'(u), 0);
        check("rst_v", int'(v), 0);
        check("rst_angle", int'(angle), 0);
        check("rst_ready", int'(ready), 0);
        cyc(0, 1, 1); cyc(0, 0, 1);
        check("idle_u", int'(u), 0);
        check("idle_v", int'(v), 0);

        // speed 0: angle 0, zoom 4, du = 127*4
        speed = 2'd0;
        cyc(1, 0, 0);
        idle(2);
        check("ready_t2", int'(ready), 0);
        idle(1);
        check("ready_t3", int'(ready), 1);
        check("s0_angle", int'(angle), 0);
        cyc(0, 1, 0);
        check("s0_p0", int'(u), 16'h0000);
        cyc(0, 0, 1);
        check("s0_p1", int'(u), 16'h01FC);
        cyc(0, 0, 1);
        check("s0_p2", int'(u), 16'h03F8);
        cyc(0, 0, 1);
        check("s0_p3", int'(u), 16'h05F4);
        check("s0_v", int'(v), 0);
        cyc(0, 1, 0);
        check("s0_l2u", int'(u), 0);
        check("s0_l2v", int'(v), 16'h01FC);

        // speed 2 for 8 frames: angle 16, zoom 6, dv = 127*6
        speed = 2'd2;
        for (int f = 0; f < 8; f++) begin cyc(1, 0, 0); idle(5); end
        check("s2_angle", int'(angle), 16);
        cyc(0, 1, 0); cyc(0, 0, 1);
        check("s2_v1", int'(v), 16'h02FA);
        check("s2_u1", int'(u), 0);
        cyc(0, 1, 0);
        check("s2_l2u", int'(u), 16'hFD06);
        check("s2_l2v", int'(v), 0);

        // pause: angle/zoom frozen, rows cleared, same step
        pause = 1'b1;
        cyc(1, 0, 0); idle(4);
        pause = 1'b0;
        check("pz_angle", int'(angle), 16);
        cyc(0, 1, 0);
        check("pz_rowu", int'(u), 0);
        cyc(0, 0, 1);
        check("pz_v1", int'(v), 16'h02FA);

        // wrap and priority with du = 0x01FC
        do_reset();
        speed = 2'd0;
        cyc(1, 0, 0); idle(4);
        cyc(0, 1, 0);
        for (int i = 0; i < 130; i++) cyc(0, 0, 1);
        check("wrap_u", int'(u), 16'h01F8);
        cyc(0, 1, 1);
        check("prio_u", int'(u), 0);
        check("prio_v", int'(v), 16'h01FC);

        // restart during COS advances angle again
        speed = 2'd1;
        cyc(1, 0, 0); idle(1);
        cyc(1, 0, 0);
        check("rs_angle", int'(angle), 2);
        check("rs_ready", int'(ready), 0);
        idle(3);
        check("rs_ready3", int'(ready), 1);

        // async reset during RUN
        cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 0, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_u", int'(u), 0);
        check("ar_v", int'(v), 0);
        check("ar_ready", int'(ready), 0);
        @(negedge clk);
        reset = 1'b0;

        // randomized traffic, compared every cycle by the model
        for (int i = 0; i < 2000; i++) begin
            speed = 2'($urandom_range(0, 3));
            pause = ($urandom_range(0, 3) == 0);
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end
        pause = 1'b0;
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
